// File: rtl/tanhx_result_fifo.sv
// tanhx_result_fifo: FWFT result buffer with almost-full back-pressure and frame marking; RANGE_CHECK_EN clamps out-of-range words to +/-1.0
module tanhx_result_fifo #(
    parameter int DWIDTH       = 32,
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 4,
    parameter int FRAME_LEN    = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DWIDTH-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DWIDTH-1:0]        out_data,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     full,
    output logic                     overflow
`ifdef RANGE_CHECK_EN
    ,
    output logic                     range_err
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr, rptr;
    logic [CW-1:0]     cnt;
    logic [FW-1:0]     fcnt;
    logic              push, pop, fend, oor;
    logic [DWIDTH-1:0] wdata;

    // Handshake decode and status flags, all derived from the registered occupancy
    always_comb begin
        out_valid   = cnt != '0;
        full        = cnt == CW'(DEPTH);
        almost_full = cnt >= CW'(DEPTH - AFULL_MARGIN);
        pop         = out_valid && out_ready;
        push        = in_valid && (!full || pop);
        fend        = fcnt == FW'(FRAME_LEN - 1);
        out_last    = out_valid && fend;
        out_data    = out_valid ? mem[rptr] : '0;
        count       = cnt;
    end

`ifdef RANGE_CHECK_EN
    // Anything above |1.0| (including inf/NaN, exponent 255) becomes signed 1.0
    always_comb begin
        oor   = in_data[30:23] > 8'd127 || (in_data[30:23] == 8'd127 && in_data[22:0] != '0);
        wdata = oor ? {in_data[31], 8'h7F, 23'd0} : in_data;
    end
`else
    // Words are stored bit-exact
    always_comb begin
        oor   = 1'b0;
        wdata = in_data;
    end
`endif

    // Storage; not reset since out_data is masked while empty
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wptr] <= wdata;
    end

    // Pointers, occupancy, frame position and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            fcnt     <= '0;
            overflow <= 1'b0;
`ifdef RANGE_CHECK_EN
            range_err <= 1'b0;
`endif
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
            if (in_valid && !push) overflow <= 1'b1;
            if (pop) fcnt <= fend ? '0 : fcnt + FW'(1);
`ifdef RANGE_CHECK_EN
            if (push && oor) range_err <= 1'b1;
`endif
        end
    end

`ifndef RANGE_CHECK_EN
    logic unused_oor;
    assign unused_oor = oor;
`endif
endmodule

// File: tb/tb_tanhx_result_fifo.sv
// tb_tanhx_result_fifo: scoreboard bench for tanhx_result_fifo (FRAME_LEN=4); honours RANGE_CHECK_EN
module tb_tanhx_result_fifo;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, out_valid, out_last, full, almost_full, overflow;
    logic [31:0] in_data, out_data;
    logic [4:0]  count;
`ifdef RANGE_CHECK_EN
    logic        range_err;
`endif
    int          tests = 0, fails = 0;
    logic [31:0] q[$];
    int          mcnt, mfc;
    bit          movf, mrerr;

    always #5 clk = ~clk;

    tanhx_result_fifo #(.DWIDTH(32), .DEPTH(16), .AFULL_MARGIN(4), .FRAME_LEN(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .count(count), .almost_full(almost_full), .full(full), .overflow(overflow)
`ifdef RANGE_CHECK_EN
        , .range_err(range_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sub(input logic [31:0] w);
`ifdef RANGE_CHECK_EN
        if (w[30:23] == 8'hFF || w[30:23] > 8'd127 || (w[30:23] == 8'd127 && w[22:0] != 0))
            return w[31] ? 32'hBF800000 : 32'h3F800000;
`endif
        return w;
    endfunction

    task automatic check_status();
        chk("count", 32'(count), 32'(mcnt));
        chk("out_valid", 32'(out_valid), 32'(mcnt != 0));
        chk("full", 32'(full), 32'(mcnt == 16));
        chk("almost_full", 32'(almost_full), 32'(mcnt >= 12));
        chk("overflow", 32'(overflow), 32'(movf));
`ifdef RANGE_CHECK_EN
        chk("range_err", 32'(range_err), 32'(mrerr));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 32'hDEADBEEF; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete(); mcnt = 0; mfc = 0; movf = 0; mrerr = 0;
        check_status();
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_last", 32'(out_last), 32'h0);
    endtask

    task automatic cycle(input bit iv, input logic [31:0] d, input bit ordy);
        bit pop, push;
        logic [31:0] exp;
        in_valid = iv; in_data = iv ? d : 32'hDEADBEEF; out_ready = ordy;
        pop = mcnt != 0 && ordy;
        if (pop) begin
            exp = q.pop_front();
            chk("pop_data", out_data, exp);
            chk("pop_last", 32'(out_last), 32'(mfc == 3));
            mfc = mfc == 3 ? 0 : mfc + 1;
        end
        push = iv && (mcnt < 16 || pop);
        if (push) begin
            q.push_back(sub(d));
            if (sub(d) !== d) mrerr = 1;
        end else if (iv) movf = 1;
        mcnt += int'(push) - int'(pop);
        @(negedge clk);
        check_status();
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        repeat (5) cycle(1'b0, 32'h0, 1'b0);
        chk("idle_out_data", out_data, 32'h0);

        cycle(1'b1, 32'h3DC87635, 1'b1);
        cycle(1'b1, 32'h3F38300C, 1'b1);
        cycle(1'b1, 32'hBF6A9B8E, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);

        do_reset();
        for (int i = 1; i <= 17; i++) cycle(1'b1, 32'(i), 1'b0);
        repeat (17) cycle(1'b0, 32'h0, 1'b1);

        do_reset();
        for (int i = 1; i <= 16; i++) cycle(1'b1, 32'(i), 1'b0);
        cycle(1'b1, 32'hAAAA0000, 1'b1);
        repeat (16) cycle(1'b0, 32'h0, 1'b1);

        do_reset();
        for (int i = 1; i <= 9; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b1);
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b1);
        cycle(1'b0, 32'h0, 1'b1);

`ifdef RANGE_CHECK_EN
        do_reset();
        cycle(1'b1, 32'h40000000, 1'b0);
        cycle(1'b1, 32'hFFC00000, 1'b0);
        cycle(1'b1, 32'h3F000000, 1'b0);
        repeat (3) cycle(1'b0, 32'h0, 1'b1);
`endif

        do_reset();
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), $urandom, i < 200 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0);
        repeat (17) cycle(1'b0, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tanhx_result_fifo.md
Name: tanhx_result_fifo

Overview:
Downstream stage of the tanh approximation unit. Captures every 32-bit IEEE-754 result the unit presents with valid high and buffers it in a small first-word-fall-through FIFO. Drains the buffer to the consumer over a valid/ready handshake and marks frame boundaries. The tanh unit has no ready input, so this block returns an almost-full back-pressure signal that the issuing logic uses to drop start.

Parameters:
DWIDTH, 32, data word width (IEEE-754 single)
DEPTH, 16, FIFO entries; power of two, at least 8
AFULL_MARGIN, 4, free slots left when almost_full asserts; covers the tanh unit's 3-cycle pipeline plus 1 issue register
FRAME_LEN, 64, popped words per frame; out_last marks the final word of each frame

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  result-valid strobe from the tanh unit
in_data  input  DWIDTH  result word (y_out); X when in_valid is low
out_valid  output  1  head word available
out_ready  input  1  consumer accepts the head word
out_data  output  DWIDTH  head word
out_last  output  1  head word is the last word of the current frame
count  output  $clog2(DEPTH)+1  current occupancy
almost_full  output  1  count >= DEPTH-AFULL_MARGIN
full  output  1  count == DEPTH
overflow  output  1  sticky; a valid result was dropped

Behaviour:
- Reset values (rst high at an edge): out_valid=0, out_data=0, out_last=0, count=0, full=0, almost_full=0, overflow=0. Read pointer, write pointer and frame counter are 0.
- Reset mid-operation flushes all stored words. A push or pop in the reset cycle is ignored.
- Push condition: in_valid && (!full || pop), where pop = out_valid && out_ready. in_data is sampled only when in_valid is high, so X on an idle bus never enters storage.
- Push while full without a same-cycle pop: the word is dropped, overflow=1 from the next cycle until rst, count is unchanged.
- Pop condition: out_valid && out_ready. out_ready while empty has no effect.
- Simultaneous push and pop: both take effect and count is unchanged. When full, the pushed word takes the freed slot.
- FWFT latency: a word pushed at edge N gives out_valid=1 and out_data equal to that word from edge N onward (visible in cycle N+1). Pop-to-next-word latency is 0: after the pop edge, out_data shows the next entry.
- out_data and out_valid are stable while out_valid && !out_ready.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is registered and updated as +1, -1 or 0 per cycle.
- full, almost_full and out_valid (= count != 0) are decoded from the registered count.
- Frame counter:
  - counts 0..FRAME_LEN-1 and increments on each pop;
  - out_last = out_valid && (frame counter == FRAME_LEN-1);
  - wraps to 0 on the pop of the last word.
- Words pass through bit-exact; there is no format conversion.

Optional Feature:
RANGE_CHECK_EN
- Defined:
  - Each pushed word is checked before storage. A word is out of range if its exponent is 255, or its magnitude is > 1.0 (exponent > 127, or exponent == 127 with a non-zero mantissa).
  - An out-of-range word is replaced by the signed value 1.0: 32'h3F800000 if sign=0, 32'hBF800000 if sign=1. NaN uses its sign bit.
  - Adds output port range_err (1 bit, sticky). It resets to 0 and is set the cycle after any substitution.
- Undefined: words are stored unchanged and the range_err port is absent.

Test Plan:
- Reset then idle: rst for 2 cycles, in_valid=0 for 5 cycles -> out_valid=0, count=0, overflow=0, out_data=0.
- Pass-through: push 32'h3DC87635, 32'h3F38300C, 32'hBF6A9B8E with out_ready=1 -> same three words appear in order, one cycle after each push, and count stays <= 1.
- Fill and overflow: out_ready=0, push 17 words 32'h00000001..32'h00000011 -> almost_full rises after the 12th push, full after the 16th, overflow=1 after the 17th. Draining then returns 1..16 only.
- Full with simultaneous push and pop: with 16 stored words, push 32'hAAAA0000 while out_ready=1 -> count stays 16, overflow stays 0, 32'hAAAA0000 is the 16th word read out after the current head.
- Frame marking with FRAME_LEN=4: stream 9 words with out_ready=1 -> out_last is high on the 4th and 8th popped words only. Assert rst after the 9th push -> buffer empty and frame counter restarts, so out_last is next seen on the 4th word after reset.
- RANGE_CHECK_EN defined: push 32'h40000000 (2.0), 32'hFFC00000 (negative NaN), 32'h3F000000 -> stored 32'h3F800000, 32'hBF800000, 32'h3F000000, and range_err=1 from the cycle after the first push.
